obstacle_field: RTL
===================

# obstacle_field

Parametrised obstacle ("bean") manager for the goose-run playfield. It holds N_OBJ obstacle slots that scroll left on each frame tick at a runtime-selectable speed. Slots that leave the screen respawn behind the last obstacle, with an LFSR-randomised gap and type. It answers per-pixel queries from the VGA scan with a registered hit/colour result, freezes on a collision pulse and restarts on command. It sits between the VGA timing/pixel counter and the top-level colour mux, alongside the goose renderer.

## Interface
- N_OBJ, 3: number of obstacle slots (2..8).
- POS_W, 12: width of unsigned slot position registers.
- SPEED_W, 4: width of speed input.
- INIT_X0, 250: initial left-edge x of slot 0.
- INIT_GAP, 250: initial spacing between consecutive slots.
- GAP_MIN, 200: minimum respawn gap.
- OBJ_W, 30: obstacle width in pixels.
- OBJ_H, 40: obstacle height in pixels.
- FLOOR_Y, 400: top y of floor-type obstacle.
- FLY_Y, 320: top y of flying-type obstacle.
- LFSR_SEED, 16'hACE1: LFSR reset value (must be nonzero).
- RGB_FLOOR, 12'h840 / RGB_FLY, 12'hC60: colours per type.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per frame; advances positions.
- speed  in  SPEED_W  pixels moved per tick; 0 = stationary.
- hit  in  1  collision pulse; freezes the field.
- restart  in  1  synchronous game restart.
- x, y  in  10 each  current scan pixel.
- bean  out  1  registered: pixel (x,y) lies inside any obstacle.
- bean_rgb  out  12  registered colour of that obstacle; 0 when bean=0.
- frozen  out  1  field is frozen.
- passed  out  1  one-cycle pulse when a slot respawns (score event).

## Operation
- Slot i state: pos[i] (POS_W, left edge), typ[i] (0 = floor, 1 = flying). tail register: x of the rightmost obstacle.
- Reset (reset=0) or restart=1:
  - pos[i] = INIT_X0 + i*INIT_GAP; typ[i] = i[0].
  - tail = INIT_X0 + (N_OBJ-1)*INIT_GAP.
  - frozen=0, passed=0, bean=0, bean_rgb=0.
  - LFSR reloads to LFSR_SEED on reset only; restart leaves the LFSR running.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk cycle.
- Tick update, when frame_tick=1, frozen=0 and restart=0:
  - Every slot with pos[i] >= speed becomes pos[i]-speed.
  - tail becomes tail-speed, saturating at 0.
- Expiry: a slot with pos[i] < speed is expired.
  - The lowest-index expired slot k respawns this tick: pos[k] = max(tail', 640) + GAP_MIN + lfsr[7:0], saturating at 2^POS_W-1. typ[k] = lfsr[8]. tail = pos[k]. passed pulses for 1 cycle.
  - Other expired slots are set to pos = 0 and respawn on later ticks, one per tick, in index order.
- Freeze: hit=1 sets frozen=1. While frozen, pos, typ and tail are held, and pixel output continues. Only reset or restart clears frozen.
- Pixel test for slot i:
  - x >= pos[i] and x < pos[i]+OBJ_W, compared at POS_W+1 bits so there is no wrap.
  - y >= top and y < top+OBJ_H, where top is FLOOR_Y or FLY_Y per typ[i].
  - Lowest matching index supplies the colour.

## Timing
- Pixel path: bean and bean_rgb reflect the (x,y) sampled at edge n, and appear after edge n. Latency is 1 clk.
- Position update is visible on the pixel path 1 clk after the frame_tick edge.
- Same-cycle priority: restart > hit > frame_tick. hit together with frame_tick: no movement that tick, frozen=1.
- An async reset assertion mid-tick clears all state immediately. Deassertion takes effect synchronously.
- passed is high for exactly the cycle after the respawning tick edge. It never fires while frozen.

## Test plan
- Reset with defaults, then x=260, y=410 -> bean=1, bean_rgb=12'h840 after 1 clk. With x=260, y=300 -> bean=0, rgb=0.
- speed=5, 10 frame_ticks -> pos = 200, 450, 700 (slot 1 is flying: x=460, y=330 gives RGB_FLY).
- speed=5, ticks until slot 0 reaches pos<5 (the 51st tick) -> passed pulses once. New pos[0] = max(tail,640) + 200 + lfsr[7:0]; check against a model LFSR.
- hit during a tick, then 20 more ticks -> positions unchanged, frozen=1. Then restart -> pos = 250, 500, 750, frozen=0.
- N_OBJ=4, INIT_GAP=5, speed=15: multiple slots expire together -> one respawn per tick in index order, and passed fires on consecutive ticks.
- Assert reset asynchronously between clk edges while bean=1 -> bean=0 and frozen=0 immediately, with positions at their initial values.

Source files
------------

// File: rtl/obstacle_field_if.sv
// Pixel-query, control and status bundle between the playfield controller and
// the obstacle manager.
interface obstacle_field_if #(
    parameter int unsigned SPEED_W = 4
);
    logic               frame_tick;
    logic [SPEED_W-1:0] speed;
    logic               hit;
    logic               restart;
    logic [9:0]         x;
    logic [9:0]         y;
    logic               bean;
    logic [11:0]        bean_rgb;
    logic               frozen;
    logic               passed;

    modport master (
        output frame_tick, speed, hit, restart, x, y,
        input  bean, bean_rgb, frozen, passed
    );

    modport slave (
        input  frame_tick, speed, hit, restart, x, y,
        output bean, bean_rgb, frozen, passed
    );
endinterface

// File: rtl/obstacle_field.sv
// Scrolling obstacle slots with LFSR respawn, freeze/restart control and a
// registered per-pixel hit/colour lookup for the VGA scan.
module obstacle_field #(
    parameter int unsigned N_OBJ     = 3,
    parameter int unsigned POS_W     = 12,
    parameter int unsigned SPEED_W   = 4,
    parameter int unsigned INIT_X0   = 250,
    parameter int unsigned INIT_GAP  = 250,
    parameter int unsigned GAP_MIN   = 200,
    parameter int unsigned OBJ_W     = 30,
    parameter int unsigned OBJ_H     = 40,
    parameter int unsigned FLOOR_Y   = 400,
    parameter int unsigned FLY_Y     = 320,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [11:0] RGB_FLOOR = 12'h840,
    parameter logic [11:0] RGB_FLY   = 12'hC60
) (
    input  logic              clk,
    input  logic              reset,
    obstacle_field_if.slave   bus
);

    localparam int unsigned CW       = POS_W + 1;
    localparam int unsigned SW       = POS_W + 2;
    localparam int unsigned YW       = 11;
    localparam int unsigned SCREEN_W = 640;
    localparam logic [POS_W-1:0] POS_MAX   = '1;
    localparam logic [POS_W-1:0] TAIL_INIT = POS_W'(INIT_X0 + (N_OBJ - 1) * INIT_GAP);

    logic [POS_W-1:0] pos_q [N_OBJ];
    logic [POS_W-1:0] pos_d [N_OBJ];
    logic [N_OBJ-1:0] typ_q, typ_d;
    logic [POS_W-1:0] tail_q, tail_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             frozen_q, frozen_d;
    logic             passed_q, passed_d;
    logic             bean_q, bean_d;
    logic [11:0]      rgb_q, rgb_d;

    logic [POS_W-1:0] spd, tail_dec, spawn_pos;
    logic [SW-1:0]    spawn_base, spawn_sum;
    logic             spawned;
    logic             pix_hit;
    logic [11:0]      pix_rgb;
    logic [CW-1:0]    px_x;
    logic [YW-1:0]    px_y, top;

    // Respawn target: behind the decremented tail (never on screen), plus gap and jitter.
    always_comb begin : spawn_calc
        spd        = POS_W'(bus.speed);
        tail_dec   = (tail_q >= spd) ? tail_q - spd : '0;
        spawn_base = (SW'(tail_dec) > SW'(SCREEN_W)) ? SW'(tail_dec) : SW'(SCREEN_W);
        spawn_sum  = spawn_base + SW'(GAP_MIN) + SW'(lfsr_q[7:0]);
        spawn_pos  = (spawn_sum > SW'(POS_MAX)) ? POS_MAX : spawn_sum[POS_W-1:0];
    end

    // Pixel hit test; lowest matching slot supplies the colour.
    always_comb begin : pixel_calc
        px_x    = CW'(bus.x);
        px_y    = YW'(bus.y);
        pix_hit = 1'b0;
        pix_rgb = '0;
        top     = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            top = typ_q[i] ? YW'(FLY_Y) : YW'(FLOOR_Y);
            if (!pix_hit &&
                px_x >= CW'(pos_q[i]) && px_x < CW'(pos_q[i]) + CW'(OBJ_W) &&
                px_y >= top && px_y < top + YW'(OBJ_H)) begin
                pix_hit = 1'b1;
                pix_rgb = typ_q[i] ? RGB_FLY : RGB_FLOOR;
            end
        end
    end

    // Field next state: restart beats hit beats frame_tick.
    always_comb begin : next_state
        pos_d    = pos_q;
        typ_d    = typ_q;
        tail_d   = tail_q;
        frozen_d = frozen_q;
        passed_d = 1'b0;
        spawned  = 1'b0;
        lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        bean_d   = pix_hit;
        rgb_d    = pix_rgb;

        if (bus.restart) begin
            for (int i = 0; i < N_OBJ; i++) begin
                pos_d[i] = POS_W'(INIT_X0 + i * INIT_GAP);
                typ_d[i] = 1'(i % 2);
            end
            tail_d   = TAIL_INIT;
            frozen_d = 1'b0;
            bean_d   = 1'b0;
            rgb_d    = '0;
        end else if (bus.hit) begin
            frozen_d = 1'b1;
        end else if (bus.frame_tick && !frozen_q) begin
            tail_d = tail_dec;
            for (int i = 0; i < N_OBJ; i++) begin
                if (pos_q[i] >= spd) begin
                    pos_d[i] = pos_q[i] - spd;
                end else if (!spawned) begin
                    pos_d[i] = spawn_pos;
                    typ_d[i] = lfsr_q[8];
                    tail_d   = spawn_pos;
                    spawned  = 1'b1;
                    passed_d = 1'b1;
                end else begin
                    pos_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_OBJ; i++) begin
                pos_q[i] <= POS_W'(INIT_X0 + i * INIT_GAP);
                typ_q[i] <= 1'(i % 2);
            end
            tail_q   <= TAIL_INIT;
            lfsr_q   <= LFSR_SEED;
            frozen_q <= 1'b0;
            passed_q <= 1'b0;
            bean_q   <= 1'b0;
            rgb_q    <= '0;
        end else begin
            pos_q    <= pos_d;
            typ_q    <= typ_d;
            tail_q   <= tail_d;
            lfsr_q   <= lfsr_d;
            frozen_q <= frozen_d;
            passed_q <= passed_d;
            bean_q   <= bean_d;
            rgb_q    <= rgb_d;
        end
    end

    assign bus.bean     = bean_q;
    assign bus.bean_rgb = rgb_q;
    assign bus.frozen   = frozen_q;
    assign bus.passed   = passed_q;

endmodule
